// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one data-memory transaction per accepted op over a
// valid/ready request channel, with byte-lane store steering and extended load results.
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   output logic              busy,
   output logic              done,
   output logic [31:0]       load_data,
   output logic              misaligned,
   output logic              illegal,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic [31:0]       mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      RESP  = 3'd2,
      DONE  = 3'd3,
      FAULT = 3'd4
   } state_t;

   function automatic logic load_f3_ok(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_f3_ok = 1'b1;
         default:                                load_f3_ok = 1'b0;
      endcase
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: store_f3_ok = 1'b1;
         default:                store_f3_ok = 1'b0;
      endcase
   endfunction

   // funct3[1:0] carries the access size for both loads and stores
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   is_misaligned = off[0];
         2'b10:   is_misaligned = (off != 2'b00);
         default: is_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         3'b000:  store_mask = 4'b0001 << off;
         3'b001:  store_mask = 4'b0011 << off;
         3'b010:  store_mask = 4'b1111;
         default: store_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
      case (f3)
         3'b000:  store_lanes = {4{sd[7:0]}};
         3'b001:  store_lanes = {2{sd[15:0]}};
         default: store_lanes = sd;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [2:0] f3);
      logic [31:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
         3'b100:  load_extract = {24'd0, sh[7:0]};
         3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
         3'b101:  load_extract = {16'd0, sh[15:0]};
         default: load_extract = sh;
      endcase
   endfunction

   state_t      state_r;
   state_t      next_s;
   logic        accept_s;
   logic        illegal_s;
   logic        misal_s;
   logic [3:0]  we_s;
   logic [2:0]  funct3_r;
   logic [1:0]  off_r;
   logic        is_load_r;

   assign accept_s = (state_r == IDLE) && op_valid && (is_load || is_store);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic and access classification of the op offered in IDLE
   always_comb begin
      next_s    = state_r;
      illegal_s = 1'b0;
      misal_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               illegal_s = (is_load && is_store) ||
                           (is_load && !load_f3_ok(funct3)) ||
                           (is_store && !store_f3_ok(funct3));
               misal_s   = !illegal_s && is_misaligned(funct3, addr[1:0]);
               next_s    = (illegal_s || misal_s) ? FAULT : REQ;
            end else begin
               next_s = IDLE;
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               next_s = RESP;
            end else begin
               next_s = REQ;
            end
         end
         RESP: begin
            if (mem_resp_valid) begin
               next_s = DONE;
            end else begin
               next_s = RESP;
            end
         end
         DONE:    next_s = IDLE;
         FAULT:   next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Write mask is computed on acceptance and then held for the whole request phase
   always_comb begin
      we_s = mem_we;
      if (accept_s) begin
         we_s = is_store ? store_mask(funct3, addr[1:0]) : 4'b0000;
      end else begin
         we_s = mem_we;
      end
   end

   // Control outputs registered from the next state so they track state exactly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         misaligned    <= 1'b0;
         illegal       <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_we        <= 4'b0000;
      end else begin
         busy          <= (next_s != IDLE);
         done          <= (next_s == DONE) || (next_s == FAULT);
         misaligned    <= (next_s == FAULT) && misal_s;
         illegal       <= (next_s == FAULT) && illegal_s;
         mem_req_valid <= (next_s == REQ);
         mem_we        <= (next_s == REQ) ? we_s : 4'b0000;
      end
   end

   // Capture of the accepted op; request fields stay stable until the next acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
         funct3_r  <= 3'd0;
         off_r     <= 2'd0;
         is_load_r <= 1'b0;
      end else if (accept_s) begin
         mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
         mem_wdata <= store_lanes(funct3, store_data);
         funct3_r  <= funct3;
         off_r     <= addr[1:0];
         is_load_r <= is_load;
      end
   end

   // Load result updates only on a load response; responses outside RESP are ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_data <= 32'd0;
      end else if ((state_r == RESP) && mem_resp_valid && is_load_r) begin
         load_data <= load_extract(mem_rdata, off_r, funct3_r);
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected completions and
// requests; a memory model and a done monitor pop and compare independently.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic        illegal;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
      .load_data(load_data), .misaligned(misaligned), .illegal(illegal),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      string       name;
      logic        mis;
      logic        ill;
      logic [31:0] ld;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  we;
      logic [31:0] wd;
      logic        chk_wd;
   } req_t;

   exp_t exp_q[$];
   req_t req_q[$];
   int   tests = 0;
   int   fails = 0;
   int   wait_cycles = 0;
   bit   drop_resp = 1'b0;
   bit   stray = 1'b0;
   int   req_seen = 0;
   int   viol = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Memory model: ready after wait_cycles, response in the cycle after the handshake
   initial begin
      bit hs;
      int wc;
      hs = 1'b0;
      wc = 0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hs = 1'b0;
            wc = 0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
         end else begin
            mem_resp_valid = (hs && !drop_resp) || stray;
            hs = 1'b0;
            if (mem_req_valid) begin
               req_seen++;
               if (req_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_req: got addr 0x%08h, none required", mem_addr);
               end else begin
                  chk("req_addr", mem_addr, req_q[0].a);
                  chk("req_we", {28'd0, mem_we}, {28'd0, req_q[0].we});
                  if (req_q[0].chk_wd) chk("req_wdata", mem_wdata, req_q[0].wd);
               end
               if (wc >= wait_cycles) begin
                  mem_req_ready = 1'b1;
                  hs = 1'b1;
                  wc = 0;
                  if (req_q.size() > 0) void'(req_q.pop_front());
               end else begin
                  mem_req_ready = 1'b0;
                  wc++;
               end
            end else begin
               mem_req_ready = 1'b0;
               wc = 0;
            end
         end
      end
   end

   // Completion monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && done) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1, none required (load_data 0x%08h)", load_data);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
               chk({e.name, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
               chk({e.name, "_load_data"}, load_data, e.ld);
            end
         end else if (!reset && (misaligned || illegal)) begin
            viol++;
         end
      end
   end

   task automatic do_op(input string name, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                        input int wt, input logic want_req, input logic [31:0] xaddr,
                        input logic [3:0] xwe, input logic [31:0] xwd, input logic chk_wd,
                        input logic xmis, input logic xill, input logic [31:0] xld,
                        input int xlat);
      req_t r;
      exp_t e;
      int   n;
      int   start_seen;
      bit   busy_ok;
      wait_cycles = wt;
      mem_rdata   = rd;
      if (want_req) begin
         r.a = xaddr; r.we = xwe; r.wd = xwd; r.chk_wd = chk_wd;
         req_q.push_back(r);
      end
      e.name = name; e.mis = xmis; e.ill = xill; e.ld = xld;
      exp_q.push_back(e);
      start_seen = req_seen;
      @(negedge clk);
      op_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 30) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      if (n >= 30) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done in 30 cycles, required done", name);
      end else begin
         // done is captured downstream on edge n+1 after the sample edge
         chk({name, "_latency"}, n + 1, xlat);
         chk({name, "_busy"}, {31'd0, busy_ok && busy}, 32'd1);
      end
      if (!want_req) chk({name, "_no_req"}, req_seen - start_seen, 32'd0);
      @(negedge clk);
      chk({name, "_done_pulse"}, {29'd0, done, misaligned, illegal}, 32'd0);
      chk({name, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int idle_bad;
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      int idle_bad;
      reset = 1'b1; op_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
      addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {26'd0, busy, done, misaligned, illegal, mem_req_valid, 1'b0}, 32'd0);
      chk("reset_we", {28'd0, mem_we}, 32'd0);
      chk("reset_load_data", load_data, 32'd0);
      reset = 1'b0;

      //     name   ld    st    f3      addr          sd            rdata         wt req  xaddr         xwe      xwd           cwd   mis   ill   xld           lat
      do_op("lb",   1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,       32'h80FF_1234, 0, 1'b1, 32'h0000_1000, 4'b0000, 32'h0,       1'b0, 1'b0, 1'b0, 32'hFFFF_FF80, 3);
      do_op("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0,       32'h80FF_1234, 0, 1'b1, 32'h0000_1000, 4'b0000, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0000_0080, 3);
      do_op("sh",   1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,       4, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 7);
      do_op("lw_mis",1'b1,1'b0, 3'b010, 32'h0000_3001, 32'h0,       32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0000_0080, 1);
      do_op("ld011",1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0,       32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0000_0080, 1);
      do_op("ldst", 1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0,       32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0000_0080, 1);
      do_op("sb",   1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h1234_56A5, 32'h0,       0, 1'b1, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 3);
      do_op("lh",   1'b1, 1'b0, 3'b001, 32'h0000_6002, 32'h0,       32'h8001_7FFF, 1, 1'b1, 32'h0000_6000, 4'b0000, 32'h0,       1'b0, 1'b0, 1'b0, 32'hFFFF_8001, 4);
      do_op("sw",   1'b0, 1'b1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 32'h0,       0, 1'b1, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'hFFFF_8001, 3);
      do_op("lw",   1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,       32'h1234_5678, 0, 1'b1, 32'h0000_0010, 4'b0000, 32'h0,       1'b0, 1'b0, 1'b0, 32'h1234_5678, 3);
      do_op("lh_mis",1'b1,1'b0, 3'b001, 32'h0000_6001, 32'h0,       32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,       1'b0, 1'b1, 1'b0, 32'h1234_5678, 1);
      do_op("st100",1'b0, 1'b1, 3'b100, 32'h0000_7000, 32'h0,       32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,       1'b0, 1'b0, 1'b1, 32'h1234_5678, 1);

      // op_valid without a load or store kind must not start anything
      @(negedge clk);
      op_valid = 1'b1; funct3 = 3'b010; addr = 32'h0000_0020;
      idle_bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy || mem_req_valid || done) idle_bad++;
      end
      op_valid = 1'b0;
      chk("no_kind_ignored", idle_bad, 32'd0);

      // Reset while waiting in RESP, then a stray response in IDLE
      drop_resp = 1'b1;
      wait_cycles = 0;
      mem_rdata = 32'hFFFF_FFFF;
      begin
         req_t r;
         r.a = 32'h0000_8000; r.we = 4'b0000; r.wd = 32'h0; r.chk_wd = 1'b0;
         req_q.push_back(r);
      end
      @(negedge clk);
      op_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h0000_8000;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0; is_load = 1'b0;
      @(negedge clk);
      chk("resp_wait", {30'd0, busy, mem_req_valid}, 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("midreset_ctrl", {26'd0, busy, done, misaligned, illegal, mem_req_valid, 1'b0}, 32'd0);
      chk("midreset_we", {28'd0, mem_we}, 32'd0);
      chk("midreset_load_data", load_data, 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      drop_resp = 1'b0;
      @(posedge clk);
      #1 stray = 1'b1;
      @(posedge clk);
      #1 stray = 1'b0;
      @(negedge clk);
      chk("stray_load_data", load_data, 32'd0);
      chk("stray_busy", {31'd0, busy}, 32'd0);

      do_op("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0,       32'h8001_0000, 0, 1'b1, 32'h0000_4000, 4'b0000, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0000_8001, 3);

      repeat (2) @(negedge clk);
      chk("flags_outside_fault", viol, 32'd0);
      chk("exp_queue_drained", exp_q.size(), 32'd0);
      chk("req_queue_drained", req_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
